board_io_ctrl: RTL and testbench

Parametrised board I/O and status controller that sits between the FPGA pins and the M0 AHB-Lite SoC top. It debounces the push buttons and latches the SoC output word on `DataValid`, showing it as hex digits. It also generates the heartbeat and running indicators and provides a status display mode. The number of display digits, the number of buttons, the debounce time, the heartbeat rate and the valid-hold time are all parameters.

---
 rtl/board_io_ctrl.sv | 179 +++++++++++++++++
 tb/tb_board_io_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_io_ctrl.sv
// Board I/O and status controller: button synchroniser/debounce, SoC data latch, heartbeat,
// and seven-segment hex/status/lockup display. Define BOARD_IO_DEBOUNCE_EN to include the debounce filter.
module board_io_ctrl #(
    parameter int NUM_DIGITS      = 4,
    parameter int NUM_BUTTONS     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int HB_MSB          = 25,
    parameter int VALID_HOLD      = 2**20
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic [NUM_BUTTONS-1:0]  KEY_n,
    output logic [NUM_BUTTONS-1:0]  Buttons,
    output logic [NUM_BUTTONS-1:0]  ButtonPress,
    input  logic [4*NUM_DIGITS-1:0] DataOut,
    input  logic                    DataValid,
    input  logic                    LOCKUP,
    input  logic                    DisplayMode,
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic                    heartbeat,
    output logic                    running
);
    localparam int VW = $clog2(VALID_HOLD + 1);

    localparam logic [6:0]        SEG_BLANK = 7'b1111111;
    localparam logic [6:0]        SEG_L     = 7'b1000111;
    localparam logic [6:0]        SEG_O     = 7'b0100011;
    localparam logic [6:0]        SEG_D     = 7'b0100001;
    localparam logic [6:0]        SEG_R     = 7'b0101111;
    localparam logic [HB_MSB:0]   HB_ONE    = 1;
    localparam logic [VW-1:0]     V_ONE     = 1;
    localparam logic [VW-1:0]     V_LOAD    = VW'(VALID_HOLD);

    if (NUM_DIGITS < 4 || NUM_DIGITS > 8 || NUM_BUTTONS < 1 || DEBOUNCE_CYCLES < 2 ||
        HB_MSB < 2 || VALID_HOLD < 1) begin : g_bad_params
        $error("board_io_ctrl: parameter out of range");
    end

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    logic [NUM_BUTTONS-1:0] key_meta_q, key_sync_q, sync;
    logic [NUM_BUTTONS-1:0] buttons, btn_prev_q, press_q;

    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            key_meta_q <= '1;
            key_sync_q <= '1;
        end else begin
            key_meta_q <= KEY_n;
            key_sync_q <= key_meta_q;
        end
    end

    assign sync = ~key_sync_q;

`ifdef BOARD_IO_DEBOUNCE_EN
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DB_ONE  = 1;

    logic [NUM_BUTTONS-1:0] stable_q, stable_d;
    logic [CW-1:0]          db_cnt_q [NUM_BUTTONS];
    logic [CW-1:0]          db_cnt_d [NUM_BUTTONS];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            db_cnt_d[i] = '0;
            if (sync[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
                end
            end
        end
    end

    // NOTE: the counter array is small and must restart from zero, so it is reset like any register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            stable_q <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) db_cnt_q[i] <= '0;
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < NUM_BUTTONS; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    assign buttons = stable_q;
`else
    assign buttons = sync;
`endif

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            btn_prev_q <= '0;
            press_q    <= '0;
        end else begin
            btn_prev_q <= buttons;
            press_q    <= buttons & ~btn_prev_q;
        end
    end

    assign Buttons     = buttons;
    assign ButtonPress = press_q;

    logic                    running_q;
    logic [HB_MSB:0]         hb_cnt_q;
    logic                    heartbeat_q;
    logic [4*NUM_DIGITS-1:0] data_q;
    logic [VW-1:0]           vcnt_q;
    logic                    vflag;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

    assign vflag = (vcnt_q != '0);

    // Lockup takes priority over both display modes.
    always_comb begin
        hex_d = '1;
        if (LOCKUP) begin
            for (int i = 0; i < NUM_DIGITS; i++) hex_d[7*i +: 7] = heartbeat_q ? SEG_L : SEG_BLANK;
        end else if (DisplayMode) begin
            hex_d[6:0]   = heartbeat_q ? SEG_O : SEG_BLANK;
            hex_d[13:7]  = vflag       ? SEG_D : SEG_BLANK;
            hex_d[20:14] = running_q   ? SEG_R : SEG_BLANK;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) hex_d[7*i +: 7] = hex_seg(data_q[4*i +: 4]);
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            running_q   <= 1'b0;
            hb_cnt_q    <= '0;
            heartbeat_q <= 1'b0;
            data_q      <= '0;
            vcnt_q      <= '0;
            hex_q       <= '1;
        end else begin
            running_q   <= 1'b1;
            hb_cnt_q    <= hb_cnt_q + HB_ONE;
            heartbeat_q <= hb_cnt_q[HB_MSB] & hb_cnt_q[HB_MSB-2];
            hex_q       <= hex_d;
            if (DataValid) begin
                data_q <= DataOut;
                vcnt_q <= V_LOAD;
            end else if (vflag) begin
                vcnt_q <= vcnt_q - V_ONE;
            end
        end
    end

    assign HEX       = hex_q;
    assign heartbeat = heartbeat_q;
    assign running   = running_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Scoreboard bench for board_io_ctrl: stimulus queues edge-stamped expectations, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_board_io_ctrl;
    localparam int ND  = 4;
    localparam int NB  = 2;
    localparam int DB  = 8;
    localparam int HBM = 4;
    localparam int VH  = 16;
`ifdef BOARD_IO_DEBOUNCE_EN
    localparam int LAT = DB + 2;
`else
    localparam int LAT = 2;
`endif

    localparam logic [6:0]  S_BLANK = 7'b1111111;
    localparam logic [6:0]  S_L     = 7'b1000111;
    localparam logic [6:0]  S_O     = 7'b0100011;
    localparam logic [6:0]  S_D     = 7'b0100001;
    localparam logic [6:0]  S_R     = 7'b0101111;
    localparam logic [27:0] ALL_BLANK = {4{S_BLANK}};
    localparam logic [27:0] ALL_ZERO  = {4{7'b1000000}};
    localparam logic [27:0] HEX_1234  = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};

    localparam logic [15:0] HV_DATA [4] = '{16'hA1F0, 16'h4D86, 16'hBCE5, 16'h9732};
    localparam logic [27:0] HV_HEX  [4] = '{
        {7'b0001000, 7'b1111001, 7'b0001110, 7'b1000000},
        {7'b0011001, 7'b0100001, 7'b0000000, 7'b0000010},
        {7'b0000011, 7'b1000110, 7'b0000110, 7'b0010010},
        {7'b0010000, 7'b1111000, 7'b0110000, 7'b0100100}
    };

    logic            HCLK = 1'b0;
    logic            HRESET = 1'b1;
    logic [NB-1:0]   KEY_n = '1;
    logic [NB-1:0]   Buttons, ButtonPress;
    logic [4*ND-1:0] DataOut = '0;
    logic            DataValid = 1'b0;
    logic            LOCKUP = 1'b0;
    logic            DisplayMode = 1'b0;
    logic [7*ND-1:0] HEX;
    logic            heartbeat, running;

    board_io_ctrl #(
        .NUM_DIGITS(ND), .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DB), .HB_MSB(HBM), .VALID_HOLD(VH)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .KEY_n(KEY_n), .Buttons(Buttons), .ButtonPress(ButtonPress),
        .DataOut(DataOut), .DataValid(DataValid), .LOCKUP(LOCKUP), .DisplayMode(DisplayMode),
        .HEX(HEX), .heartbeat(heartbeat), .running(running)
    );

    always #5 HCLK = ~HCLK;

    int edge_n = 0;
    always @(posedge HCLK) edge_n <= edge_n + 1;

    typedef enum {SEL_HEX, SEL_BTN, SEL_PRESS, SEL_RUN, SEL_HB} sel_e;
    typedef struct {
        int          cyc;
        sel_e        sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   rel_edge = 0;

    task automatic expect_at(input int cyc, input sel_e sel, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc = cyc; e.sel = sel; e.val = val; e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    function automatic logic [31:0] actual(input sel_e s);
        case (s)
            SEL_HEX:   return 32'(HEX);
            SEL_BTN:   return 32'(Buttons);
            SEL_PRESS: return 32'(ButtonPress);
            SEL_RUN:   return 32'(running);
            default:   return 32'(heartbeat);
        endcase
    endfunction

    // Heartbeat value held after edge n: the counter is (j-1) mod 32 just before the j-th edge since release.
    function automatic logic hb_after(input int n);
        int         j;
        logic [4:0] c;
        j = n - rel_edge;
        if (j < 1) return 1'b0;
        c = 5'((j - 1) % 32);
        return c[4] & c[2];
    endfunction

    function automatic logic [27:0] status_hex(input int n, input logic vf);
        return {S_BLANK, S_R, vf ? S_D : S_BLANK, hb_after(n - 1) ? S_O : S_BLANK};
    endfunction

    initial begin
        logic [31:0] act;
        forever begin
            @(negedge HCLK);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= edge_n) begin
                    n_vec++;
                    act = actual(sb[i].sel);
                    if (sb[i].cyc < edge_n) begin
                        n_miss++;
                        $display("FAIL %s: check for edge %0d missed (now %0d)", sb[i].name, sb[i].cyc, edge_n);
                    end else if (act !== sb[i].val) begin
                        n_miss++;
                        $display("FAIL %s @edge %0d: got %h, want %h", sb[i].name, edge_n, act, sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        int          e0, e1, k;
        logic [27:0] prev_hex;

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_at(edge_n, SEL_HEX, 32'(ALL_BLANK), "rst_hex");
            expect_at(edge_n, SEL_BTN, 0, "rst_btn");
            expect_at(edge_n, SEL_RUN, 0, "rst_run");
        end
        HRESET = 1'b0;
        rel_edge = edge_n;
        expect_at(edge_n + 1, SEL_RUN, 1, "run_after_rst");
        expect_at(edge_n + 1, SEL_PRESS, 0, "press_after_rst");
        tick();
        tick();

        // Hex latch: four words covering all sixteen digit glyphs.
        prev_hex = ALL_ZERO;
        for (int v = 0; v < 4; v++) begin
            e0 = edge_n;
            DataOut   = HV_DATA[v];
            DataValid = 1'b1;
            expect_at(e0 + 1, SEL_HEX, 32'(prev_hex), "hex_old");
            expect_at(e0 + 2, SEL_HEX, 32'(HV_HEX[v]), "hex_new");
            expect_at(e0 + 5, SEL_HEX, 32'(HV_HEX[v]), "hex_hold");
            tick();
            DataValid = 1'b0;
            DataOut   = ~HV_DATA[v];
            repeat (5) tick();
            prev_hex = HV_HEX[v];
        end

        // Short low glitch on KEY_n[0].
        e0 = edge_n;
        KEY_n[0] = 1'b0;
`ifdef BOARD_IO_DEBOUNCE_EN
        for (int j = 1; j <= 14; j++) begin
            expect_at(e0 + j, SEL_BTN, 0, "glitch_btn");
            expect_at(e0 + j, SEL_PRESS, 0, "glitch_press");
        end
`else
        expect_at(e0 + 1, SEL_BTN, 0, "glitch_btn_pre");
        expect_at(e0 + 2, SEL_BTN, 1, "glitch_btn_rise");
        expect_at(e0 + 3, SEL_PRESS, 1, "glitch_press");
        expect_at(e0 + 4, SEL_PRESS, 0, "glitch_press_end");
        expect_at(e0 + 6, SEL_BTN, 1, "glitch_btn_held");
        expect_at(e0 + 7, SEL_BTN, 0, "glitch_btn_fall");
`endif
        repeat (5) tick();
        KEY_n[0] = 1'b1;
        repeat (12) tick();

        // Held press, then release.
        e0 = edge_n;
        KEY_n[0] = 1'b0;
        expect_at(e0 + LAT - 1, SEL_BTN, 0, "press_btn_early");
        expect_at(e0 + LAT,     SEL_BTN, 1, "press_btn_rise");
        expect_at(e0 + LAT,     SEL_PRESS, 0, "press_pulse_pre");
        expect_at(e0 + LAT + 1, SEL_PRESS, 1, "press_pulse");
        expect_at(e0 + LAT + 2, SEL_PRESS, 0, "press_pulse_end");
        expect_at(e0 + LAT + 5, SEL_PRESS, 0, "press_pulse_quiet");
        expect_at(e0 + LAT + 5, SEL_BTN, 1, "press_btn_held");
        repeat (LAT + 6) tick();
        e0 = edge_n;
        KEY_n[0] = 1'b1;
        expect_at(e0 + LAT - 1, SEL_BTN, 1, "release_btn_early");
        expect_at(e0 + LAT,     SEL_BTN, 0, "release_btn_fall");
        for (int j = LAT; j <= LAT + 2; j++) expect_at(e0 + j, SEL_PRESS, 0, "release_no_press");
        repeat (LAT + 20) tick();

        // Status mode and valid stretch.
        e0 = edge_n;
        DisplayMode = 1'b1;
        expect_at(e0 + 1, SEL_HEX, 32'(status_hex(e0 + 1, 1'b0)), "status_idle");
        tick();
        tick();
        e1 = edge_n;
        k  = e1 + 1;
        DataValid = 1'b1;
        expect_at(k,      SEL_HEX, 32'(status_hex(k, 1'b0)),      "status_pre_valid");
        expect_at(k + 1,  SEL_HEX, 32'(status_hex(k + 1, 1'b1)),  "status_valid_on");
        expect_at(k + 16, SEL_HEX, 32'(status_hex(k + 16, 1'b1)), "status_valid_last");
        expect_at(k + 17, SEL_HEX, 32'(status_hex(k + 17, 1'b0)), "status_valid_off");
        tick();
        DataValid = 1'b0;
        repeat (20) tick();

        e1 = edge_n;
        k  = e1 + 1;
        DataValid = 1'b1;
        expect_at(k + 1,  SEL_HEX, 32'(status_hex(k + 1, 1'b1)),  "stretch_on");
        expect_at(k + 17, SEL_HEX, 32'(status_hex(k + 17, 1'b1)), "stretch_extended");
        expect_at(k + 26, SEL_HEX, 32'(status_hex(k + 26, 1'b1)), "stretch_last");
        expect_at(k + 27, SEL_HEX, 32'(status_hex(k + 27, 1'b0)), "stretch_off");
        tick();
        DataValid = 1'b0;
        repeat (9) tick();
        DataValid = 1'b1;
        tick();
        DataValid = 1'b0;
        repeat (20) tick();
        DisplayMode = 1'b0;
        tick();

        // Lockup blink over one full heartbeat period, with a data load during lockup.
        e0 = edge_n;
        LOCKUP = 1'b1;
        for (int j = 1; j <= 32; j++) begin
            expect_at(e0 + j, SEL_HEX, hb_after(e0 + j - 1) ? 32'({4{S_L}}) : 32'(ALL_BLANK), "lockup_hex");
            expect_at(e0 + j, SEL_HB, 32'(hb_after(e0 + j)), "heartbeat");
        end
        repeat (10) tick();
        DataOut   = 16'h1234;
        DataValid = 1'b1;
        tick();
        DataValid = 1'b0;
        repeat (21) tick();
        e1 = edge_n;
        LOCKUP = 1'b0;
        expect_at(e1 + 1, SEL_HEX, 32'(HEX_1234), "lockup_latch_loaded");
        repeat (3) tick();

        // Asynchronous reset mid-debounce with the valid indicator lit.
        DisplayMode = 1'b1;
        DataValid   = 1'b1;
        tick();
        DataValid = 1'b0;
        KEY_n[0]  = 1'b0;
        repeat (5) tick();
        HRESET = 1'b1;
        expect_at(edge_n, SEL_HEX, 32'(ALL_BLANK), "midrst_hex");
        expect_at(edge_n, SEL_BTN, 0, "midrst_btn");
        expect_at(edge_n, SEL_PRESS, 0, "midrst_press");
        expect_at(edge_n, SEL_RUN, 0, "midrst_run");
        expect_at(edge_n, SEL_HB, 0, "midrst_hb");
        tick();
        KEY_n = '1;
        DisplayMode = 1'b0;
        tick();
        HRESET = 1'b0;
        rel_edge = edge_n;
        expect_at(rel_edge + 1, SEL_RUN, 1, "midrst_run_after");
        expect_at(rel_edge + 1, SEL_HEX, 32'(ALL_ZERO), "midrst_latch_cleared");
        for (int j = 1; j <= LAT + 4; j++) begin
            expect_at(rel_edge + j, SEL_BTN, 0, "midrst_btn_after");
            expect_at(rel_edge + j, SEL_PRESS, 0, "midrst_press_after");
        end

        for (int t = 0; t < 200 && sb.size() > 0; t++) tick();
        if (sb.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
